simple_rx_check: RTL and testbench

Packet checker that sits directly downstream of the simple test-packet generator on the 64-bit AXI4-Stream datapath. It accepts every beat and checks each packet's header word, body words, byte strobes and length against fixed expected values. It keeps good-packet, bad-packet and beat counters plus the error code of the most recent bad packet, for register readout by the surrounding wrapper.

---
 rtl/simple_rx_pkg.sv | 23 ++
 rtl/simple_rx_check.sv | 143 ++++++++++++++
 tb/tb_simple_rx_check.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/simple_rx_pkg.sv
// Shared definitions for the simple test-packet generator/checker pair.
package simple_rx_pkg;

  typedef enum logic [0:0] {
    StSop,
    StInPkt
  } rx_state_e;

  localparam int unsigned ERR_HDR  = 0;
  localparam int unsigned ERR_BODY = 1;
  localparam int unsigned ERR_LEN  = 2;
  localparam int unsigned ERR_STRB = 3;
  localparam int unsigned ERR_W    = 4;

  localparam logic [63:0] HDR_PATTERN_DEFAULT  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BODY_PATTERN_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  // Beat index never wraps so over-long packets keep reporting a length error.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/simple_rx_check.sv
// AXI4-Stream packet checker: validates header, body, strobes and length of each packet
// and keeps good/bad/beat statistics for register readout.
module simple_rx_check
  import simple_rx_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_CHECK_PKT_SIZE     = 2,
  parameter logic [63:0] C_HDR_PATTERN        = HDR_PATTERN_DEFAULT,
  parameter logic [63:0] C_BODY_PATTERN       = BODY_PATTERN_DEFAULT,
  parameter int unsigned C_CNT_WIDTH          = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              rx_enable,
  input  logic                              rst_cntrs,
  output logic [C_CNT_WIDTH-1:0]            rx_count,
  output logic [C_CNT_WIDTH-1:0]            err_count,
  output logic [C_CNT_WIDTH-1:0]            beat_count,
  output logic [ERR_W-1:0]                  last_err_code,
  output logic                              pkt_ok
);

  localparam logic [16:0] PktSize = 17'(C_CHECK_PKT_SIZE);
  localparam logic [C_CNT_WIDTH-1:0] CntOne = C_CNT_WIDTH'(1);

  rx_state_e state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [ERR_W-1:0] flags_q, flags_d;
  logic [ERR_W-1:0] cur_err, final_err;
  logic [C_CNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [C_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [C_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [ERR_W-1:0] last_err_q, last_err_d;
  logic pkt_ok_q, pkt_ok_d;

  logic beat, first, pkt_end;
  logic [16:0] beat_num;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // Once a packet has started it is always drained, regardless of rx_enable.
  assign s_axis_tready = rx_enable | (state_q == StInPkt);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign first         = (state_q == StSop);
  assign pkt_end       = beat & s_axis_tlast;

  // 1-based number of the beat currently on the bus.
  assign beat_num = first ? 17'd1 : ({1'b0, idx_q} + 17'd1);

  always_comb begin
    cur_err           = '0;
    cur_err[ERR_HDR]  = first & (s_axis_tdata != C_HDR_PATTERN);
    cur_err[ERR_BODY] = ~first & (s_axis_tdata != C_BODY_PATTERN);
    cur_err[ERR_LEN]  = s_axis_tlast ? (beat_num != PktSize) : (beat_num > PktSize);
    cur_err[ERR_STRB] = (s_axis_tstrb != '1);
  end

  assign final_err = flags_q | cur_err;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    if (beat) begin
      unique case (state_q)
        StSop: begin
          idx_d   = 16'd1;
          state_d = s_axis_tlast ? StSop : StInPkt;
        end
        StInPkt: begin
          idx_d   = sat_inc16(idx_q);
          state_d = s_axis_tlast ? StSop : StInPkt;
        end
        default: state_d = StSop;
      endcase
      flags_d = s_axis_tlast ? '0 : final_err;
    end
  end

  always_comb begin
    rx_count_d   = rx_count_q;
    err_count_d  = err_count_q;
    beat_count_d = beat_count_q;
    last_err_d   = last_err_q;
    pkt_ok_d     = 1'b0;
    if (beat) begin
      beat_count_d = beat_count_q + CntOne;
    end
    if (pkt_end) begin
      if (final_err == '0) begin
        rx_count_d = rx_count_q + CntOne;
        pkt_ok_d   = 1'b1;
      end else begin
        err_count_d = err_count_q + CntOne;
        last_err_d  = final_err;
      end
    end
    // Statistics clear wins over any same-cycle increment; pkt_ok is not a statistic.
    if (rst_cntrs) begin
      rx_count_d   = '0;
      err_count_d  = '0;
      beat_count_d = '0;
      last_err_d   = '0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= StSop;
      idx_q        <= '0;
      flags_q      <= '0;
      rx_count_q   <= '0;
      err_count_q  <= '0;
      beat_count_q <= '0;
      last_err_q   <= '0;
      pkt_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      flags_q      <= flags_d;
      rx_count_q   <= rx_count_d;
      err_count_q  <= err_count_d;
      beat_count_q <= beat_count_d;
      last_err_q   <= last_err_d;
      pkt_ok_q     <= pkt_ok_d;
    end
  end

  assign rx_count      = rx_count_q;
  assign err_count     = err_count_q;
  assign beat_count    = beat_count_q;
  assign last_err_code = last_err_q;
  assign pkt_ok        = pkt_ok_q;

endmodule

// File: tb/tb_simple_rx_check.sv
// Directed, table-driven bench for simple_rx_check with hand-computed expectations.
module tb_simple_rx_check;

  localparam logic [63:0] H = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] B = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  tdata;
  logic [7:0]   tstrb;
  logic [127:0] tuser;
  logic         tvalid, tready, tlast;
  logic         rx_enable, rst_cntrs;
  logic [31:0]  rx_count, err_count, beat_count;
  logic [3:0]   last_err_code;
  logic         pkt_ok;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  simple_rx_check dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tstrb  (tstrb),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .rx_enable     (rx_enable),
    .rst_cntrs     (rst_cntrs),
    .rx_count      (rx_count),
    .err_count     (err_count),
    .beat_count    (beat_count),
    .last_err_code (last_err_code),
    .pkt_ok        (pkt_ok)
  );

  typedef struct {
    logic        valid;
    logic        last;
    logic        en;
    logic        rc;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        exp_tready;
    logic [31:0] exp_rx;
    logic [31:0] exp_err;
    logic [31:0] exp_beat;
    logic [3:0]  exp_code;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic valid, input logic last, input logic en,
                              input logic rc, input logic [63:0] data,
                              input logic [7:0] strb, input logic tr,
                              input int unsigned rx, input int unsigned er,
                              input int unsigned bt, input logic [3:0] code,
                              input logic ok);
    vec_t v;
    v.valid = valid; v.last = last; v.en = en; v.rc = rc; v.data = data; v.strb = strb;
    v.exp_tready = tr; v.exp_rx = rx; v.exp_err = er; v.exp_beat = bt;
    v.exp_code = code; v.exp_ok = ok;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_outs(input string tag, input int unsigned rx, input int unsigned er,
                            input int unsigned bt, input logic [3:0] code, input logic ok);
    check({tag, " rx_count"},      rx_count,      64'(rx));
    check({tag, " err_count"},     err_count,     64'(er));
    check({tag, " beat_count"},    beat_count,    64'(bt));
    check({tag, " last_err_code"}, last_err_code, 64'(code));
    check({tag, " pkt_ok"},        pkt_ok,        64'(ok));
  endtask

  task automatic drive(input logic valid, input logic last, input logic [63:0] data,
                       input logic [7:0] strb);
    tvalid = valid; tlast = last; tdata = data; tstrb = strb;
  endtask

  initial begin
    rst_n = 1'b0; rx_enable = 1'b1; rst_cntrs = 1'b0; tuser = {4{32'hDEAD_BEEF}};
    drive(1'b0, 1'b0, 64'h0, 8'hFF);

    // Three good packets
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 1, 0, 2, 4'h0, 1));
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 1, 0, 3, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 2, 0, 4, 4'h0, 1));
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 2, 0, 5, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 3, 0, 6, 4'h0, 1));
    // Bad header
    vecs.push_back(mk(1, 0, 1, 0, 64'h0, 8'hFF, 1, 3, 0, 7, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B,     8'hFF, 1, 3, 1, 8, 4'h1, 0));
    // 3-beat packet, then single-beat packet
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 3, 1, 9,  4'h1, 0));
    vecs.push_back(mk(1, 0, 1, 0, B, 8'hFF, 1, 3, 1, 10, 4'h1, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 3, 2, 11, 4'h4, 0));
    vecs.push_back(mk(1, 1, 1, 0, H, 8'hFF, 1, 3, 3, 12, 4'h4, 0));
    // Body mismatch plus partial strobe
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 3, 3, 13, 4'h4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 64'h0123_4567_89AB_CDEF, 8'h0F, 1, 3, 4, 14, 4'hA, 0));
    vecs.push_back(mk(0, 0, 1, 0, H, 8'hFF, 1, 3, 4, 14, 4'hA, 0));
    // Statistics clear coinciding with a good tlast
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 3, 4, 15, 4'hA, 0));
    vecs.push_back(mk(1, 1, 1, 1, B, 8'hFF, 1, 0, 0, 0, 4'h0, 1));
    vecs.push_back(mk(0, 0, 1, 0, H, 8'hFF, 1, 0, 0, 0, 4'h0, 0));
    // rx_enable dropped mid-packet, next packet held off
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 0, 0, 1, 4'h0, 0));
    vecs.push_back(mk(1, 1, 0, 0, B, 8'hFF, 1, 1, 0, 2, 4'h0, 1));
    vecs.push_back(mk(1, 0, 0, 0, H, 8'hFF, 0, 1, 0, 2, 4'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, H, 8'hFF, 0, 1, 0, 2, 4'h0, 0));
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 1, 0, 3, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 2, 0, 4, 4'h0, 1));
    // Strobe error on the header beat only
    vecs.push_back(mk(1, 0, 1, 0, H, 8'h7F, 1, 2, 0, 5, 4'h0, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 2, 1, 6, 4'h8, 0));
    // 4-beat packet: overrun flagged before tlast
    vecs.push_back(mk(1, 0, 1, 0, H, 8'hFF, 1, 2, 1, 7,  4'h8, 0));
    vecs.push_back(mk(1, 0, 1, 0, B, 8'hFF, 1, 2, 1, 8,  4'h8, 0));
    vecs.push_back(mk(1, 0, 1, 0, B, 8'hFF, 1, 2, 1, 9,  4'h8, 0));
    vecs.push_back(mk(1, 1, 1, 0, B, 8'hFF, 1, 2, 2, 10, 4'h4, 0));
    vecs.push_back(mk(0, 0, 0, 0, H, 8'hFF, 0, 2, 2, 10, 4'h4, 0));

    repeat (3) @(negedge clk);
    #1;
    check("reset tready", tready, 64'd1);
    check_outs("reset", 0, 0, 0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].strb);
      rx_enable = vecs[i].en;
      rst_cntrs = vecs[i].rc;
      #1;
      check($sformatf("v%0d tready", i), tready, 64'(vecs[i].exp_tready));
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].exp_rx, vecs[i].exp_err, vecs[i].exp_beat,
                 vecs[i].exp_code, vecs[i].exp_ok);
    end

    // Async reset in the middle of a packet
    @(negedge clk);
    rx_enable = 1'b1; rst_cntrs = 1'b0;
    drive(1'b1, 1'b0, H, 8'hFF);
    @(posedge clk);
    #1;
    check("pre-reset beat_count", beat_count, 64'd11);
    drive(1'b0, 1'b0, B, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0, 4'h0, 1'b0);
    check("async reset tready en1", tready, 64'd1);
    rx_enable = 1'b0;
    #1;
    check("async reset tready en0", tready, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rx_enable = 1'b1;
    drive(1'b1, 1'b0, H, 8'hFF);
    @(posedge clk);
    #1;
    check_outs("post-reset hdr", 0, 0, 1, 4'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, B, 8'hFF);
    @(posedge clk);
    #1;
    check_outs("post-reset pkt", 1, 0, 2, 4'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, H, 8'hFF);
    @(posedge clk);
    #1;
    check("pkt_ok single cycle", pkt_ok, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
